// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: configurable data width, parity and stop bits.
// Each bit is decided by a 3-sample majority vote near mid-bit.
module uart_rx_os #(
  parameter int p_data_bits  = 8,
  parameter int p_parity     = 2,
  parameter int p_stop_bits  = 1,
  parameter int p_oversample = 16
) (
  input  logic                   w_baud_clk,
  input  logic                   i_rst,
  input  logic                   i_rx,
  input  logic                   i_ready,
  output logic                   o_valid,
  output logic [p_data_bits-1:0] o_data,
  output logic                   o_perr,
  output logic                   o_ferr,
  output logic                   o_break,
  output logic                   o_overrun,
  output logic                   o_busy
);

  localparam int CW = $clog2(p_oversample);
  localparam int IW = $clog2(p_data_bits + 1);
  localparam logic [CW-1:0] C_MAX     = CW'(p_oversample - 1);
  // Registered c equals p_oversample/2 on the edge where it advances to p_oversample/2+1.
  localparam logic [CW-1:0] C_VOTE    = CW'(p_oversample / 2);
  localparam logic [IW-1:0] LAST_DATA = IW'(p_data_bits - 1);
  localparam logic [IW-1:0] LAST_STOP = IW'(p_stop_bits - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_HIGH
  } state_t;

  state_t                 state;
  logic                   rx_meta, rx_sync;
  logic [1:0]             hist;
  logic [CW-1:0]          c;
  logic [IW-1:0]          bit_idx;
  logic [p_data_bits-1:0] data_r;
  logic                   par_r, perr_r, ferr_r, brk_r;
  logic                   vote, vote_edge, brk_first, brk_now, ferr_now;

  assign vote      = (hist[1] & hist[0]) | (hist[1] & rx_sync) | (hist[0] & rx_sync);
  assign vote_edge = (c == C_VOTE);
  assign brk_first = (data_r == '0) && ((p_parity == 0) || !par_r) && !vote;
  assign brk_now   = (bit_idx == '0) ? brk_first : brk_r;
  assign ferr_now  = ferr_r | !vote;

  // Handshake: o_valid with o_data/o_perr/o_ferr/o_break is one frame, held
  // stable until an edge with o_valid && i_ready, which consumes it.
  always_ff @(posedge w_baud_clk or negedge i_rst) begin
    if (!i_rst) begin
      state     <= S_IDLE;
      rx_meta   <= 1'b1;
      rx_sync   <= 1'b1;
      hist      <= 2'b11;
      c         <= '0;
      bit_idx   <= '0;
      data_r    <= '0;
      par_r     <= 1'b0;
      perr_r    <= 1'b0;
      ferr_r    <= 1'b0;
      brk_r     <= 1'b0;
      o_valid   <= 1'b0;
      o_data    <= '0;
      o_perr    <= 1'b0;
      o_ferr    <= 1'b0;
      o_break   <= 1'b0;
      o_overrun <= 1'b0;
      o_busy    <= 1'b0;
    end else begin
      rx_meta <= i_rx;
      rx_sync <= rx_meta;
      hist    <= {hist[0], rx_sync};

      if (state == S_IDLE) c <= '0;
      else                 c <= (c == C_MAX) ? '0 : c + 1'b1;

      if (o_valid && i_ready) begin
        o_valid   <= 1'b0;
        o_overrun <= 1'b0;
      end

      case (state)
        S_IDLE: begin
          if (!rx_sync) begin
            state  <= S_START;
            o_busy <= 1'b1;
          end
        end
        S_START: begin
          if (vote_edge) begin
            if (vote) begin
              state  <= S_IDLE;
              o_busy <= 1'b0;
            end else begin
              state   <= S_DATA;
              bit_idx <= '0;
              par_r   <= 1'b0;
              perr_r  <= 1'b0;
              ferr_r  <= 1'b0;
              brk_r   <= 1'b0;
            end
          end
        end
        S_DATA: begin
          if (vote_edge) begin
            data_r <= {vote, data_r[p_data_bits-1:1]};
            if (bit_idx == LAST_DATA) begin
              bit_idx <= '0;
              state   <= (p_parity != 0) ? S_PARITY : S_STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end
        end
        S_PARITY: begin
          if (vote_edge) begin
            par_r  <= vote;
            perr_r <= (^data_r) ^ vote ^ (p_parity == 1);
            state  <= S_STOP;
          end
        end
        S_STOP: begin
          if (vote_edge) begin
            if (bit_idx == '0) brk_r <= brk_first;
            if (!vote) ferr_r <= 1'b1;
            if (bit_idx == LAST_STOP) begin
              // A frame arriving while one is still held is dropped, not queued.
              if (!o_valid || i_ready) begin
                o_valid <= 1'b1;
                o_data  <= brk_now ? '0 : data_r;
                o_perr  <= perr_r;
                o_ferr  <= ferr_now;
                o_break <= brk_now;
              end else begin
                o_overrun <= 1'b1;
              end
              if (brk_now) begin
                state <= S_WAIT_HIGH;
              end else begin
                state  <= S_IDLE;
                o_busy <= 1'b0;
              end
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end
        end
        S_WAIT_HIGH: begin
          if (rx_sync) begin
            state  <= S_IDLE;
            o_busy <= 1'b0;
          end
        end
        default: begin
          state  <= S_IDLE;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_os.sv
// Bench for uart_rx_os: an 8N1 and an 8E1 instance at 16x, checked against a
// frame-level reference model and directed latency/handshake scenarios.
module tb_uart_rx_os;

  localparam int OS = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx_n, rx_e, rdy_n, rdy_e;
  logic       v_n, perr_n, ferr_n, brk_n, ovr_n, busy_n;
  logic       v_e, perr_e, ferr_e, brk_e, ovr_e, busy_e;
  logic [7:0] d_n, d_e;

  logic [10:0] obs_n[$], obs_e[$];
  logic [10:0] exp_q[$], exp_e_q[$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_rx_os #(.p_data_bits(8), .p_parity(0), .p_stop_bits(1), .p_oversample(OS)) dut_n (
    .w_baud_clk(clk), .i_rst(rst_n), .i_rx(rx_n), .i_ready(rdy_n),
    .o_valid(v_n), .o_data(d_n), .o_perr(perr_n), .o_ferr(ferr_n),
    .o_break(brk_n), .o_overrun(ovr_n), .o_busy(busy_n));

  uart_rx_os #(.p_data_bits(8), .p_parity(2), .p_stop_bits(1), .p_oversample(OS)) dut_e (
    .w_baud_clk(clk), .i_rst(rst_n), .i_rx(rx_e), .i_ready(rdy_e),
    .o_valid(v_e), .o_data(d_e), .o_perr(perr_e), .o_ferr(ferr_e),
    .o_break(brk_e), .o_overrun(ovr_e), .o_busy(busy_e));

  // Every accepted frame is recorded as {break, ferr, perr, data}.
  always @(posedge clk) begin
    if (v_n && rdy_n) obs_n.push_back({brk_n, ferr_n, perr_n, d_n});
    if (v_e && rdy_e) obs_e.push_back({brk_e, ferr_e, perr_e, d_e});
  end

  // Frame-level reference: what a receiver must report for one transmitted frame.
  function automatic logic [10:0] model_frame(input logic [7:0] d, input bit par_en,
                                              input logic par_flip, input logic stop_v);
    logic par_bit, perr, ferr, brk;
    par_bit = par_en ? (($countones(d) % 2 == 1) ^ par_flip) : 1'b0;
    perr    = par_en && ((($countones(d) + int'(par_bit)) % 2) != 0);
    brk     = (d == 8'h00) && !par_bit && !stop_v;
    ferr    = !stop_v;
    return {brk, ferr, perr, brk ? 8'h00 : d};
  endfunction

  task automatic drive_bit(input int sel, input logic v);
    if (sel == 0) rx_n = v;
    else          rx_e = v;
    repeat (OS) @(negedge clk);
  endtask

  task automatic idle_bits(input int sel, input int n);
    for (int i = 0; i < n; i++) drive_bit(sel, 1'b1);
  endtask

  task automatic send_frame(input int sel, input logic [7:0] d, input logic par_flip,
                            input logic stop_v);
    drive_bit(sel, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(sel, d[i]);
    if (sel == 1) drive_bit(sel, (^d) ^ par_flip);
    drive_bit(sel, stop_v);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rx_n = 1'b1; rx_e = 1'b1; rdy_n = 1'b1; rdy_e = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({v_n, d_n, perr_n, ferr_n, brk_n, ovr_n, busy_n} !== 14'h0) begin
      errors++;
      $display("FAIL reset_n: got %h want 0", {v_n, d_n, perr_n, ferr_n, brk_n, ovr_n, busy_n});
    end
    checks++;
    if ({v_e, d_e, perr_e, ferr_e, brk_e, ovr_e, busy_e} !== 14'h0) begin
      errors++;
      $display("FAIL reset_e: got %h want 0", {v_e, d_e, perr_e, ferr_e, brk_e, ovr_e, busy_e});
    end
  endtask

  task automatic test_latency();
    int n;
    obs_n.delete();
    fork
      send_frame(0, 8'hA5, 1'b0, 1'b1);
      begin
        for (int i = 0; i < 64 && !busy_n; i++) @(negedge clk);
        n = 0;
        while (!v_n && n < 400) begin
          @(negedge clk);
          n++;
        end
        checks++;
        if (n != 153) begin
          errors++;
          $display("FAIL latency: got %0d edges want 153", n);
        end
        checks++;
        if ({brk_n, ferr_n, perr_n, d_n} !== model_frame(8'hA5, 0, 1'b0, 1'b1)) begin
          errors++;
          $display("FAIL latency_frame: got %h want %h", {brk_n, ferr_n, perr_n, d_n},
                   model_frame(8'hA5, 0, 1'b0, 1'b1));
        end
        @(negedge clk);
        checks++;
        if (v_n !== 1'b0) begin
          errors++;
          $display("FAIL valid_pulse: got %b want 0", v_n);
        end
      end
    join
    idle_bits(0, 1);
  endtask

  task automatic test_parity();
    obs_e.delete(); exp_e_q.delete();
    send_frame(1, 8'h3C, 1'b1, 1'b1); exp_e_q.push_back(model_frame(8'h3C, 1, 1'b1, 1'b1));
    idle_bits(1, 1);
    send_frame(1, 8'h3C, 1'b0, 1'b1); exp_e_q.push_back(model_frame(8'h3C, 1, 1'b0, 1'b1));
    idle_bits(1, 1);
    checks++;
    if (obs_e.size() != 2) begin
      errors++;
      $display("FAIL parity_count: got %0d want 2", obs_e.size());
    end
    for (int i = 0; i < 2 && i < obs_e.size(); i++) begin
      checks++;
      if (obs_e[i] !== exp_e_q[i]) begin
        errors++;
        $display("FAIL parity_frame%0d: got %h want %h", i, obs_e[i], exp_e_q[i]);
      end
    end
  endtask

  task automatic test_glitch();
    logic saw_valid, saw_busy;
    obs_n.delete();
    saw_valid = 1'b0; saw_busy = 1'b0;
    rx_n = 1'b0;
    repeat (4) @(negedge clk);
    rx_n = 1'b1;
    repeat (30) begin
      @(negedge clk);
      saw_valid |= v_n;
      saw_busy  |= busy_n;
    end
    checks++;
    if (saw_valid !== 1'b0 || busy_n !== 1'b0) begin
      errors++;
      $display("FAIL glitch_ignored: got valid %b busy %b want 0 0", saw_valid, busy_n);
    end
    checks++;
    if (saw_busy !== 1'b1) begin
      errors++;
      $display("FAIL glitch_start_seen: got %b want 1", saw_busy);
    end
    send_frame(0, 8'h55, 1'b0, 1'b1);
    idle_bits(0, 1);
    checks++;
    if (obs_n.size() != 1 || obs_n[0] !== model_frame(8'h55, 0, 1'b0, 1'b1)) begin
      errors++;
      $display("FAIL glitch_next_frame: got %0d frames first %h want 1 frame %h", obs_n.size(),
               (obs_n.size() > 0) ? obs_n[0] : 11'h0, model_frame(8'h55, 0, 1'b0, 1'b1));
    end
  endtask

  task automatic test_framing();
    obs_n.delete();
    send_frame(0, 8'h81, 1'b0, 1'b0);
    idle_bits(0, 2);
    checks++;
    if (obs_n.size() != 1 || obs_n[0] !== model_frame(8'h81, 0, 1'b0, 1'b0)) begin
      errors++;
      $display("FAIL framing: got %0d frames first %h want 1 frame %h", obs_n.size(),
               (obs_n.size() > 0) ? obs_n[0] : 11'h0, model_frame(8'h81, 0, 1'b0, 1'b0));
    end
  endtask

  task automatic test_break();
    obs_n.delete(); exp_q.delete();
    rx_n = 1'b0;
    repeat (20 * OS) @(negedge clk);
    exp_q.push_back(model_frame(8'h00, 0, 1'b0, 1'b0));
    idle_bits(0, 2);
    send_frame(0, 8'h12, 1'b0, 1'b1); exp_q.push_back(model_frame(8'h12, 0, 1'b0, 1'b1));
    idle_bits(0, 1);
    checks++;
    if (obs_n.size() != 2) begin
      errors++;
      $display("FAIL break_count: got %0d want 2", obs_n.size());
    end
    for (int i = 0; i < 2 && i < obs_n.size(); i++) begin
      checks++;
      if (obs_n[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL break_frame%0d: got %h want %h", i, obs_n[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_overrun();
    obs_n.delete();
    rdy_n = 1'b0;
    send_frame(0, 8'h11, 1'b0, 1'b1); idle_bits(0, 1);
    send_frame(0, 8'h22, 1'b0, 1'b1); idle_bits(0, 1);
    checks++;
    if ({v_n, d_n, ovr_n} !== {1'b1, 8'h11, 1'b1}) begin
      errors++;
      $display("FAIL overrun_hold: got v%b d%h ovr%b want v1 d11 ovr1", v_n, d_n, ovr_n);
    end
    rdy_n = 1'b1;
    @(negedge clk);
    rdy_n = 1'b0;
    checks++;
    if ({v_n, ovr_n} !== 2'b00) begin
      errors++;
      $display("FAIL overrun_accept: got v%b ovr%b want v0 ovr0", v_n, ovr_n);
    end
    checks++;
    if (obs_n.size() != 1 || obs_n[0] !== model_frame(8'h11, 0, 1'b0, 1'b1)) begin
      errors++;
      $display("FAIL overrun_accepted_frame: got %0d frames want 1 frame %h", obs_n.size(),
               model_frame(8'h11, 0, 1'b0, 1'b1));
    end
    // Hold a frame, start another, then reset in the middle of it.
    send_frame(0, 8'h33, 1'b0, 1'b1); idle_bits(0, 1);
    rx_n = 1'b0;
    repeat (3 * OS) @(negedge clk);
    checks++;
    if ({v_n, busy_n} !== 2'b11) begin
      errors++;
      $display("FAIL pre_reset_state: got v%b busy%b want v1 busy1", v_n, busy_n);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({v_n, d_n, perr_n, ferr_n, brk_n, ovr_n, busy_n} !== 14'h0) begin
      errors++;
      $display("FAIL async_reset: got %h want 0", {v_n, d_n, perr_n, ferr_n, brk_n, ovr_n, busy_n});
    end
    rx_n = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12 * OS) @(negedge clk);
    checks++;
    if ({v_n, busy_n} !== 2'b00) begin
      errors++;
      $display("FAIL no_partial_frame: got v%b busy%b want v0 busy0", v_n, busy_n);
    end
    rdy_n = 1'b1;
  endtask

  task automatic test_same_edge();
    int n;
    obs_n.delete(); exp_q.delete();
    rdy_n = 1'b0;
    send_frame(0, 8'h5A, 1'b0, 1'b1); idle_bits(0, 1);
    exp_q.push_back(model_frame(8'h5A, 0, 1'b0, 1'b1));
    exp_q.push_back(model_frame(8'hC3, 0, 1'b0, 1'b1));
    fork
      send_frame(0, 8'hC3, 1'b0, 1'b1);
      begin
        for (int i = 0; i < 64 && !busy_n; i++) @(negedge clk);
        n = 0;
        while (n < 152) begin
          @(negedge clk);
          n++;
        end
        rdy_n = 1'b1;
        @(negedge clk);
        rdy_n = 1'b0;
        checks++;
        if ({v_n, d_n, ovr_n} !== {1'b1, 8'hC3, 1'b0}) begin
          errors++;
          $display("FAIL same_edge_load: got v%b d%h ovr%b want v1 dc3 ovr0", v_n, d_n, ovr_n);
        end
      end
    join
    idle_bits(0, 1);
    rdy_n = 1'b1;
    @(negedge clk);
    checks++;
    if (obs_n.size() != 2) begin
      errors++;
      $display("FAIL same_edge_count: got %0d want 2", obs_n.size());
    end
    for (int i = 0; i < 2 && i < obs_n.size(); i++) begin
      checks++;
      if (obs_n[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL same_edge_frame%0d: got %h want %h", i, obs_n[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_random();
    obs_n.delete(); obs_e.delete(); exp_q.delete(); exp_e_q.delete();
    rdy_n = 1'b1; rdy_e = 1'b1;
    fork
      for (int k = 0; k < 12; k++) begin
        logic [7:0] d;
        logic       sv;
        d  = 8'($urandom_range(0, 255));
        sv = ($urandom_range(0, 5) != 0);
        exp_q.push_back(model_frame(d, 0, 1'b0, sv));
        send_frame(0, d, 1'b0, sv);
        idle_bits(0, sv ? int'($urandom_range(0, 1)) : 2);
      end
      for (int k = 0; k < 12; k++) begin
        logic [7:0] d;
        logic       sv, pf;
        d  = (k == 5) ? 8'h00 : 8'($urandom_range(0, 255));
        sv = (k == 5) ? 1'b0 : ($urandom_range(0, 5) != 0);
        pf = (k == 5) ? 1'b0 : ($urandom_range(0, 3) == 0);
        exp_e_q.push_back(model_frame(d, 1, pf, sv));
        send_frame(1, d, pf, sv);
        idle_bits(1, sv ? int'($urandom_range(0, 1)) : 2);
      end
    join
    idle_bits(0, 1);
    checks++;
    if (obs_n.size() != exp_q.size()) begin
      errors++;
      $display("FAIL rand_n_count: got %0d want %0d", obs_n.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_n.size(); i++) begin
      checks++;
      if (obs_n[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL rand_n_frame%0d: got %h want %h", i, obs_n[i], exp_q[i]);
      end
    end
    checks++;
    if (obs_e.size() != exp_e_q.size()) begin
      errors++;
      $display("FAIL rand_e_count: got %0d want %0d", obs_e.size(), exp_e_q.size());
    end
    for (int i = 0; i < exp_e_q.size() && i < obs_e.size(); i++) begin
      checks++;
      if (obs_e[i] !== exp_e_q[i]) begin
        errors++;
        $display("FAIL rand_e_frame%0d: got %h want %h", i, obs_e[i], exp_e_q[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_parity();
    test_glitch();
    test_framing();
    test_break();
    test_overrun();
    test_same_edge();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
